// File: rtl/dl_meas_ctrl_if.sv
// Bundle of the start/status, delay-line and result-stream signals of
// dl_meas_ctrl. The slave modport is the measurement controller.
// The master modport is the side that drives it (system and delay line).
interface dl_meas_ctrl_if #(
    parameter int p_dl_length = 64
);
    logic                   i_start;
    logic [7:0]             i_shots;
    logic                   o_busy;
    logic                   o_dl_tx;
    logic                   i_dl_valid;
    logic [p_dl_length-1:0] i_dl_taps;
    logic                   o_res_valid;
    logic                   i_res_ready;
    logic [7:0]             o_res_data;

    modport slave (
        input  i_start, i_shots, i_dl_valid, i_dl_taps, i_res_ready,
        output o_busy, o_dl_tx, o_res_valid, o_res_data
    );

    modport master (
        output i_start, i_shots, i_dl_valid, i_dl_taps, i_res_ready,
        input  o_busy, o_dl_tx, o_res_valid, o_res_data
    );
endinterface

// File: rtl/dl_meas_ctrl.sv
// dl_meas_ctrl: delay-line measurement controller.
// It launches a number of shots into a tapped delay line. For each capture it
// finds the first tap transition and accumulates the min, max and sum of the
// transition positions, plus a miss count. It then streams out five result
// bytes: min, max, sum[15:8], sum[7:0] and miss.
// Optional feature: define DL_MEAS_TIMEOUT_EN to turn a capture that does not
// arrive within p_timeout cycles into a miss. Without it, the controller
// waits for a capture indefinitely.
module dl_meas_ctrl #(
    parameter int p_dl_length = 64,
    parameter int p_timeout   = 255
) (
    input  logic           i_clk,
    input  logic           i_nrst,
    dl_meas_ctrl_if.slave  io_bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        WAIT   = 3'd2,
        PROC   = 3'd3,
        SEND   = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [7:0]             r_shots_left;
    logic [p_dl_length-1:0] r_taps;
    logic [7:0]             r_min;
    logic [7:0]             r_max;
    logic [15:0]            r_sum;
    logic [7:0]             r_miss;
    logic                   r_dl_tx;
    logic [2:0]             r_byte_idx;
    logic                   w_hit;
    logic [7:0]             w_pos;
    logic                   w_accept;
    logic                   w_timeout;
    logic [7:0]             w_res_data;

`ifdef DL_MEAS_TIMEOUT_EN
    logic [15:0]            r_wait_cnt;

    // A missing capture ends the wait on the last counted cycle of the window.
    assign w_timeout = (r_wait_cnt == 16'(p_timeout - 1)) && !io_bus.i_dl_valid;
`else
    assign w_timeout = 1'b0;
`endif

    assign w_accept = (r_state == SEND) && io_bus.i_res_ready;

    // The position is the first tap that differs from its predecessor.
    // The loop scans downwards so that the lowest matching index wins.
    always_comb begin
        w_hit = 1'b0;
        w_pos = 8'h00;
        for (int i = p_dl_length - 1; i >= 1; i--) begin
            if (r_taps[i] != r_taps[i-1]) begin
                w_hit = 1'b1;
                w_pos = i[7:0];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (io_bus.i_start) w_next_state = LAUNCH;
            LAUNCH:  w_next_state = WAIT;
            WAIT:    if (io_bus.i_dl_valid || w_timeout) w_next_state = PROC;
            PROC:    w_next_state = (r_shots_left == 8'd1) ? SEND : LAUNCH;
            SEND:    if (w_accept && (r_byte_idx == 3'd4)) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Datapath: shot counter, launch level, captured taps, accumulators and byte index.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_shots_left <= 8'h00;
            r_taps       <= '0;
            r_min        <= 8'h00;
            r_max        <= 8'h00;
            r_sum        <= 16'h0000;
            r_miss       <= 8'h00;
            r_dl_tx      <= 1'b0;
            r_byte_idx   <= 3'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (io_bus.i_start) begin
                        r_shots_left <= (io_bus.i_shots == 8'd0) ? 8'd1 : io_bus.i_shots;
                        r_min        <= 8'hFF;
                        r_max        <= 8'h00;
                        r_sum        <= 16'h0000;
                        r_miss       <= 8'h00;
                        r_byte_idx   <= 3'd0;
                    end
                end
                LAUNCH: begin
                    r_dl_tx <= ~r_dl_tx;
                end
                WAIT: begin
                    if (io_bus.i_dl_valid) begin
                        r_taps <= io_bus.i_dl_taps;
                    end else if (w_timeout) begin
                        // A vector with no transition makes the processing step score a miss.
                        r_taps <= '0;
                    end
                end
                PROC: begin
                    r_shots_left <= r_shots_left - 8'd1;
                    if (w_hit) begin
                        if (w_pos < r_min) r_min <= w_pos;
                        if (w_pos > r_max) r_max <= w_pos;
                        r_sum <= r_sum + {8'h00, w_pos};
                    end else if (r_miss != 8'hFF) begin
                        r_miss <= r_miss + 8'd1;
                    end
                end
                SEND: begin
                    if (w_accept) r_byte_idx <= r_byte_idx + 3'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef DL_MEAS_TIMEOUT_EN
    // The wait-cycle counter restarts at every launch and runs while waiting.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_wait_cnt <= 16'h0000;
        end else if (r_state == LAUNCH) begin
            r_wait_cnt <= 16'h0000;
        end else if (r_state == WAIT) begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
        end
    end
`endif

    // Result byte mux. It drives zero whenever no byte is being offered.
    always_comb begin
        w_res_data = 8'h00;
        if (r_state == SEND) begin
            case (r_byte_idx)
                3'd0:    w_res_data = r_min;
                3'd1:    w_res_data = r_max;
                3'd2:    w_res_data = r_sum[15:8];
                3'd3:    w_res_data = r_sum[7:0];
                3'd4:    w_res_data = r_miss;
                default: w_res_data = 8'h00;
            endcase
        end
    end

    assign io_bus.o_busy      = (r_state != IDLE);
    assign io_bus.o_dl_tx     = r_dl_tx;
    assign io_bus.o_res_valid = (r_state == SEND);
    assign io_bus.o_res_data  = w_res_data;

endmodule
